switch_debounce: RTL and testbench
==================================

Name: switch_debounce

Overview:
- Input-conditioning stage that sits directly upstream of the gate blocks (NOT, AND, OR, ...).
- Takes a raw asynchronous board switch or button and synchronises it to CLK.
- Filters contact bounce and drives a clean, stable logic level into the gate's A input.
- Also produces single-cycle rise and fall pulses for downstream counters and LEDs.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive synchronised samples required to accept a new level (10 ms at 100 MHz); legal range is 2 or more.
- CNT_WIDTH, 20, width of the stability counter; 2^CNT_WIDTH must be at least DEBOUNCE_CYCLES.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- A    input  1  raw switch input, asynchronous to CLK and bouncy.
- OUT  output 1  debounced level; feeds the downstream gate input.
- RISE output 1  one-cycle pulse when OUT goes 0->1.
- FALL output 1  one-cycle pulse when OUT goes 1->0.
- BUSY output 1  high while a candidate level change is being qualified.

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-high.
- Reset: on any CLK edge with RST=1, the following are cleared regardless of A:
  - sync flops s1 and s2 <= 0; counter <= 0; state <= IDLE_LOW.
  - OUT=0, RISE=0, FALL=0, BUSY=0.
- Synchroniser: two flops, s1<=A then s2<=s1. Only s2 is used by the FSM.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. All outputs are registered.
  - OUT=1 in IDLE_HIGH and WAIT_LOW.
  - BUSY=1 in WAIT_HIGH and WAIT_LOW.
- IDLE_LOW:
  - s2=1 -> WAIT_HIGH, counter<=1.
  - Otherwise stay, counter<=0.
- WAIT_HIGH:
  - s2=0 -> IDLE_LOW, counter<=0, no pulse (glitch rejected).
  - s2=1 and counter<DEBOUNCE_CYCLES-1 -> counter<=counter+1.
  - s2=1 and counter=DEBOUNCE_CYCLES-1 -> IDLE_HIGH, OUT<=1, RISE<=1, counter<=0.
- IDLE_HIGH and WAIT_LOW: mirror of the above with s2 polarity inverted; the commit drives OUT<=0 and FALL<=1.
- RISE and FALL:
  - Each is high for exactly one cycle, on the cycle after the commit edge.
  - Each is 0 in every other cycle.
  - They are never both high.
- Latency:
  - A settles before edge 0; s2 is valid after edge 1.
  - Samples are taken at edges 2 .. DEBOUNCE_CYCLES+1.
  - OUT changes and the pulse appears after edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 cycles total.
- Boundary conditions:
  - Acceptance requires exactly DEBOUNCE_CYCLES consecutive matching s2 samples. One mismatching sample restarts qualification from zero in the IDLE state.
  - The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
  - A held high through reset: after RST falls, it is qualified normally and produces one RISE.
  - RST asserted mid-WAIT: the qualification is abandoned and no pulse is emitted. A full latency applies after release.
  - RST has priority over every other event on the same edge.

Test Plan (DEBOUNCE_CYCLES=4, CNT_WIDTH=3):
- Reset: RST=1 for 3 cycles with A=1 -> OUT, RISE, FALL and BUSY are all 0 throughout; after release, RISE pulses once after edge 5 relative to the first post-reset edge.
- Clean rise: A 0->1 before edge 0, held 10 cycles -> BUSY=1 after edges 2, 3 and 4; OUT=1 and RISE=1 after edge 5; RISE=0 after edge 6; OUT stays 1.
- Glitch reject: from OUT=0, A=1 for exactly 3 cycles then 0 -> BUSY high for 3 cycles then 0; OUT stays 0; RISE never asserts.
- Clean fall: from OUT=1, A 1->0 held 10 cycles -> OUT=0 and FALL=1 after edge 5; FALL=0 after edge 6; RISE stays 0.
- Bounce: A=1,0,1,0,1,0 on successive cycles, then steady 1 -> exactly one RISE, occurring 6 cycles after the final 0->1 transition of A; no FALL.
- Reset mid-qualification: A=1, RST asserted at edge 3 (BUSY=1) for 1 cycle -> BUSY=0 and OUT=0 after edge 3; no RISE; after release with A still 1, RISE occurs a full 6 cycles later.

Source files
------------

// File: rtl/switch_debounce_if.sv
// switch_debounce_if: raw switch input and conditioned level/edge outputs of the debouncer
interface switch_debounce_if;
    logic A;
    logic OUT;
    logic RISE;
    logic FALL;
    logic BUSY;

    modport master (output A, input OUT, input RISE, input FALL, input BUSY);
    modport slave  (input A, output OUT, output RISE, output FALL, output BUSY);
endinterface

// File: rtl/switch_debounce.sv
// switch_debounce: two-flop synchroniser plus stability-counter FSM giving a clean level and edge pulses
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic              CLK,
    input  logic              RST,
    switch_debounce_if.slave  bus
);
    typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    state_t               r_state, w_next;
    logic                 r_s1, r_s2;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt;
    logic                 r_out, r_rise, r_fall, r_busy;
    logic                 w_done;

    assign w_done   = r_cnt == LAST;
    assign bus.OUT  = r_out;
    assign bus.RISE = r_rise;
    assign bus.FALL = r_fall;
    assign bus.BUSY = r_busy;

    // A mismatching sample in a WAIT state drops back to the IDLE state with the counter cleared
    always_comb begin
        w_next = r_state;
        w_cnt  = '0;
        case (r_state)
            IDLE_LOW:  if (r_s2) begin w_next = WAIT_HIGH; w_cnt = CNT_WIDTH'(1); end
            WAIT_HIGH: if (!r_s2) w_next = IDLE_LOW;
                       else if (w_done) w_next = IDLE_HIGH;
                       else w_cnt = r_cnt + CNT_WIDTH'(1);
            IDLE_HIGH: if (!r_s2) begin w_next = WAIT_LOW; w_cnt = CNT_WIDTH'(1); end
            WAIT_LOW:  if (r_s2) w_next = IDLE_HIGH;
                       else if (w_done) w_next = IDLE_LOW;
                       else w_cnt = r_cnt + CNT_WIDTH'(1);
            default:   w_next = IDLE_LOW;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_cnt   <= '0;
            r_state <= IDLE_LOW;
            r_out   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_s1    <= bus.A;
            r_s2    <= r_s1;
            r_cnt   <= w_cnt;
            r_state <= w_next;
            r_out   <= (w_next == IDLE_HIGH) || (w_next == WAIT_LOW);
            r_busy  <= (w_next == WAIT_HIGH) || (w_next == WAIT_LOW);
            r_rise  <= (r_state == WAIT_HIGH) && (w_next == IDLE_HIGH);
            r_fall  <= (r_state == WAIT_LOW) && (w_next == IDLE_LOW);
        end
    end
endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: directed scenario tasks for the debouncer with DEBOUNCE_CYCLES=4
module tb_switch_debounce;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   total = 0;
    int   bad = 0;

    switch_debounce_if bus();

    switch_debounce #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.A = 1'b0;
        step();
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        bus.A = 1'b1;
        RST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if ({bus.OUT, bus.RISE, bus.FALL, bus.BUSY} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got=%b want=0000", k, {bus.OUT, bus.RISE, bus.FALL, bus.BUSY});
            end
        end
        RST = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if (bus.RISE !== (k == 5)) begin
                bad++;
                $display("FAIL reset_release_rise edge=%0d got=%b want=%b", k, bus.RISE, k == 5);
            end
            total++;
            if (bus.OUT !== (k >= 5)) begin
                bad++;
                $display("FAIL reset_release_out edge=%0d got=%b want=%b", k, bus.OUT, k >= 5);
            end
        end
    endtask

    task automatic test_clean_rise();
        do_reset();
        bus.A = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if (bus.BUSY !== (k >= 2 && k <= 4)) begin
                bad++;
                $display("FAIL rise_busy edge=%0d got=%b want=%b", k, bus.BUSY, k >= 2 && k <= 4);
            end
            total++;
            if (bus.OUT !== (k >= 5)) begin
                bad++;
                $display("FAIL rise_out edge=%0d got=%b want=%b", k, bus.OUT, k >= 5);
            end
            total++;
            if ({bus.RISE, bus.FALL} !== {k == 5, 1'b0}) begin
                bad++;
                $display("FAIL rise_pulses edge=%0d got=%b want=%b", k, {bus.RISE, bus.FALL}, {k == 5, 1'b0});
            end
        end
    endtask

    task automatic test_clean_fall();
        bus.A = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if (bus.BUSY !== (k >= 2 && k <= 4)) begin
                bad++;
                $display("FAIL fall_busy edge=%0d got=%b want=%b", k, bus.BUSY, k >= 2 && k <= 4);
            end
            total++;
            if (bus.OUT !== (k < 5)) begin
                bad++;
                $display("FAIL fall_out edge=%0d got=%b want=%b", k, bus.OUT, k < 5);
            end
            total++;
            if ({bus.RISE, bus.FALL} !== {1'b0, k == 5}) begin
                bad++;
                $display("FAIL fall_pulses edge=%0d got=%b want=%b", k, {bus.RISE, bus.FALL}, {1'b0, k == 5});
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            bus.A = (k < 3);
            step();
            total++;
            if (bus.BUSY !== (k >= 2 && k <= 4)) begin
                bad++;
                $display("FAIL glitch_busy edge=%0d got=%b want=%b", k, bus.BUSY, k >= 2 && k <= 4);
            end
            total++;
            if ({bus.OUT, bus.RISE, bus.FALL} !== 3'b000) begin
                bad++;
                $display("FAIL glitch_quiet edge=%0d got=%b want=000", k, {bus.OUT, bus.RISE, bus.FALL});
            end
        end
    endtask

    task automatic test_bounce();
        logic [5:0] pat;
        int rises;
        pat = 6'b010101;
        rises = 0;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            bus.A = (k < 6) ? pat[k] : 1'b1;
            step();
            rises += int'(bus.RISE);
            total++;
            if ({bus.RISE, bus.FALL} !== {k == 11, 1'b0}) begin
                bad++;
                $display("FAIL bounce_pulses edge=%0d got=%b want=%b", k, {bus.RISE, bus.FALL}, {k == 11, 1'b0});
            end
        end
        total++;
        if (rises !== 1) begin
            bad++;
            $display("FAIL bounce_rise_count got=%0d want=1", rises);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        bus.A = 1'b1;
        for (int k = 0; k < 13; k++) begin
            RST = (k == 3);
            step();
            if (k == 2) begin
                total++;
                if (bus.BUSY !== 1'b1) begin
                    bad++;
                    $display("FAIL midrst_busy_before got=%b want=1", bus.BUSY);
                end
            end
            if (k == 3) begin
                total++;
                if ({bus.BUSY, bus.OUT} !== 2'b00) begin
                    bad++;
                    $display("FAIL midrst_cleared got=%b want=00", {bus.BUSY, bus.OUT});
                end
            end
            total++;
            if (bus.RISE !== (k == 9)) begin
                bad++;
                $display("FAIL midrst_rise edge=%0d got=%b want=%b", k, bus.RISE, k == 9);
            end
        end
    endtask

    initial begin
        bus.A = 1'b0;
        test_reset();
        test_clean_rise();
        test_clean_fall();
        test_glitch();
        test_bounce();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
